uart_tx_buffer: RTL
===================

Name: uart_tx_buffer

Overview:
- Transmit-side front end that sits directly upstream of the UART driver.
- Accepts bytes from a producer via a valid/ready handshake and stores them in a FIFO.
- Feeds the driver one word at a time on uart_tx_data, giving each word a single-cycle uart_send pulse (the driver's single-send mode).
- Paces itself on the driver's busy output, so the producer never has to watch UART timing.

Parameters:
- BIT_WIDTH, 8, width of each data word; must match the driver.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, do not override.
- START_TIMEOUT, 15, cycles to wait for uart_busy to rise after a send pulse before re-pulsing; at least 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- wr_data  in  BIT_WIDTH  word from the producer.
- wr_valid  in  1  wr_data is valid.
- wr_ready  out  1  buffer can accept; equals !full.
- flush  in  1  discard all queued words.
- uart_send  out  1  send pulse to the driver.
- uart_tx_data  out  BIT_WIDTH  word presented to the driver.
- uart_busy  in  1  driver's busy output.
- count  out  ADDR_W+1  number of queued words, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- idle  out  1  FIFO empty and FSM in IDLE.

Behaviour:
- Reset (rst==0 at a clock edge):
  - pointers, count and timeout counter = 0; state = IDLE.
  - uart_send = 0, uart_tx_data = 0.
  - Outputs after reset: wr_ready = 1, empty = 1, full = 0, idle = 1.
  - Reset mid-transfer abandons the in-flight word; there is no further handshake with the driver.
- Write: a word is accepted on an edge where wr_valid && wr_ready. A write while full is impossible because wr_ready is 0.
- Pop:
  - Occurs only on the IDLE->SEND transition; the head word is registered into uart_tx_data.
  - A write and a pop on the same edge leave count unchanged.
  - Pointers wrap modulo DEPTH.
- No bypass: a word written into an empty FIFO is visible to the FSM on the next edge.
- flush:
  - On an edge with flush==1, pointers and count go to 0. This takes priority over a same-cycle write (the write is dropped) and over a same-cycle pop (the FSM stays in IDLE).
  - flush does not abort a word already in SEND, WAIT_START or WAIT_DONE.
- FSM, fully registered; uart_send = (state==SEND):
  - IDLE:
    - if !empty && !uart_busy && !flush: pop, go to SEND.
  - SEND: one cycle, uart_send=1; clear the timeout counter; go to WAIT_START.
  - WAIT_START:
    - if uart_busy: go to WAIT_DONE.
    - else increment the timeout counter; when it reaches START_TIMEOUT, go to SEND to re-pulse with the same word.
  - WAIT_DONE: when !uart_busy, go to IDLE.
- uart_tx_data is held stable from the pop until the return to IDLE.
- uart_send is never high on two consecutive cycles.
- Latency:
  - A word written at edge N into an empty buffer with the driver idle: state=SEND after edge N+1; uart_send high during cycle N+1..N+2; the driver samples it at edge N+2.
  - Back-to-back words: the next pop occurs on the first edge where state==IDLE and uart_busy==0.
- If uart_busy is already high in IDLE (the driver is receiving or owned elsewhere), the FSM waits.
- count, empty, full and idle are registered-consistent; they update on the same edge as the pointers.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_SEND=2'd1, ST_WAIT_START=2'd2, ST_WAIT_DONE=2'd3.
  - a clog2 helper function, reused by the other UART stages.
- One sub-module, uart_fifo: synchronous FIFO with write/pop/flush, count, empty and full; parameters BIT_WIDTH and DEPTH.
- The FSM and timeout counter live in uart_tx_buffer itself.

Test Plan:
- Basic send: hold rst=0 for 2 cycles, release; write 8'hA5 at edge N with uart_busy=0; model busy rising one cycle after send and falling 10 cycles later -> uart_send high for exactly one cycle sampled at edge N+2; uart_tx_data=8'hA5; idle=1 after busy falls.
- Fill and drain:
  - With uart_busy held 1, write 8'h00..8'h0F -> full=1, count=16, wr_ready=0; a 17th write is ignored.
  - Release busy with the model running -> sixteen send pulses carrying 8'h00..8'h0F in order.
- Wrap and simultaneous events: stream 40 words with continuous wr_valid and a model driver -> output sequence equals input sequence; count never exceeds 16; count unchanged on edges with both a write and a pop.
- Timeout retry: the model ignores the first send pulse (busy stays 0) -> after 15 cycles in WAIT_START a second pulse occurs with the same uart_tx_data; the word is delivered exactly once after busy responds.
- Flush: queue 5 words, start sending the first, assert flush for 1 cycle concurrently with wr_valid -> the in-flight word completes; the remaining 4 words and the concurrent write are dropped; count=0, empty=1.
- Reset mid-transfer: drive rst=0 while in WAIT_DONE -> next edge: uart_send=0, uart_tx_data=0, count=0, idle=1; no further send pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit stages.
//   - ST_* : encoding of the transmit-buffer FSM states
//   - tx_state_e : enum built on that encoding
//   - clog2 : elaboration-time ceiling log2, used to size pointers/counters
package uart_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_SEND       = 2'd1;
  localparam logic [1:0] ST_WAIT_START = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE       = ST_IDLE,
    SEND       = ST_SEND,
    WAIT_START = ST_WAIT_START,
    WAIT_DONE  = ST_WAIT_DONE
  } tx_state_e;

  // Smallest n with 2**n >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with write, pop and flush.
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   wr_en_i/wr_data_i write request (ignored while full or flushing)
//   pop_i             remove the head word (ignored while empty or flushing)
//   flush_i           clear pointers and count; wins over write and pop
//   rd_data_o         head word (valid while !empty_o)
//   count_o           words stored, 0..DEPTH
//   empty_o, full_o   registered-consistent status flags
module uart_fifo
  import uart_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 16,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [BIT_WIDTH-1:0] wr_data_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  output logic [BIT_WIDTH-1:0] rd_data_o,
  output logic [ADDR_W:0]      count_o,
  output logic                 empty_o,
  output logic                 full_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [BIT_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]      count_q;
  logic                 do_wr, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign do_wr  = wr_en_i && !full_o && !flush_i;
  assign do_pop = pop_i && !empty_o && !flush_i;

  // Pointers are ADDR_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: transmit front end between a byte producer and the UART
// driver. Buffers words in a FIFO and hands them to the driver one at a
// time with a single-cycle uart_send pulse, pacing on uart_busy.
//
// Handshake: a word is transferred on every rising edge where
// wr_valid && wr_ready; wr_ready is !full and does not depend on wr_valid.
// The producer must hold wr_data stable while wr_valid is high and
// wr_ready is low.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   wr_data/wr_valid    producer word and its valid
//   wr_ready            buffer can accept (== !full)
//   flush               drop every queued word (an in-flight word completes)
//   uart_send           one-cycle send pulse to the driver
//   uart_tx_data        word presented to the driver, stable for a transfer
//   uart_busy           driver busy
//   count, empty, full  FIFO occupancy
//   idle                FIFO empty and FSM in IDLE
//   dbg_state           current FSM state (ST_* encoding)
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int BIT_WIDTH     = 8,
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = clog2(DEPTH),
  parameter int START_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic                 flush,
  output logic                 uart_send,
  output logic [BIT_WIDTH-1:0] uart_tx_data,
  input  logic                 uart_busy,
  output logic [ADDR_W:0]      count,
  output logic                 empty,
  output logic                 full,
  output logic                 idle,
  output logic [1:0]           dbg_state
);

  localparam int              TO_W    = clog2(START_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TIMEOUT - 1);

  tx_state_e            state_q, state_d;
  logic [TO_W-1:0]      timeout_q, timeout_d;
  logic [BIT_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [BIT_WIDTH-1:0] head_data;
  logic                 fifo_empty, fifo_full;
  logic                 pop;

  uart_fifo #(
    .BIT_WIDTH (BIT_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (wr_valid),
    .wr_data_i (wr_data),
    .pop_i     (pop),
    .flush_i   (flush),
    .rd_data_o (head_data),
    .count_o   (count),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      timeout_q <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        // flush wins over a pop on the same edge, so the FSM stays put.
        if (!fifo_empty && !uart_busy && !flush) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        timeout_d = '0;
        state_d   = WAIT_START;
      end
      WAIT_START: begin
        if (uart_busy) begin
          state_d = WAIT_DONE;
        end else if (timeout_q == TO_LAST) begin
          // Driver never acknowledged: pulse again with the same word.
          timeout_d = '0;
          state_d   = SEND;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The head word is captured only at the pop, so it stays stable across
  // retries and until the FSM returns to IDLE.
  assign tx_data_d = pop ? head_data : tx_data_q;

  assign uart_send    = (state_q == SEND);
  assign uart_tx_data = tx_data_q;
  assign wr_ready     = !fifo_full;
  assign empty        = fifo_empty;
  assign full         = fifo_full;
  assign idle         = fifo_empty && (state_q == IDLE);
  assign dbg_state    = state_q;

endmodule
